// File: rtl/fht_twiddle_seq.sv
// Twiddle ROM address sequencer for a radix-2 FHT: walks stages and butterflies, tags ROM output.
// Optional stall statistics counter enabled by defining FHT_TWIDDLE_SEQ_STAT_EN.
module fht_twiddle_seq #(
    parameter int A_BIT = 6,
    parameter int S_BIT = 3,
    parameter int GAP   = 0
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic             iSTART,
    input  logic             iSTALL,
    output logic [A_BIT-1:0] oROM_ADDR,
    output logic             oST_ZERO,
    output logic             oVALID,
    output logic [S_BIT-1:0] oSTAGE,
    output logic [A_BIT-1:0] oBF_IDX,
    output logic             oLAST,
    output logic             oBUSY,
    output logic             oDONE
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
    ,
    output logic [15:0]      oSTALL_CNT
`endif
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_GAP,
        ST_FLUSH
    } state_t;

    state_t             state_reg, state_next;
    logic [S_BIT-1:0]   s_reg, s_next;
    logic [A_BIT-1:0]   b_reg, b_next;
    logic [3:0]         gap_cnt_reg, gap_cnt_next;
    logic [A_BIT-1:0]   addr_reg, addr_next;
    logic               st_zero_reg, st_zero_next;
    logic               valid_reg, valid_next;
    logic [S_BIT-1:0]   stage_tag_reg, stage_tag_next;
    logic [A_BIT-1:0]   bf_tag_reg, bf_tag_next;
    logic               last_tag_reg, last_tag_next;
    logic               done_reg, done_next;
    logic               load_addr;
    logic               issue;
    logic               last_bf;
    logic               last_stage;
    logic [A_BIT-1:0]   k_next;

    assign issue      = (state_reg == ST_RUN) && !iSTALL;
    assign last_bf    = (b_reg == {A_BIT{1'b1}});
    assign last_stage = (s_reg == S_BIT'(A_BIT));

    always_comb begin
        state_next   = state_reg;
        s_next       = s_reg;
        b_next       = b_reg;
        gap_cnt_next = gap_cnt_reg;
        load_addr    = 1'b0;
        done_next    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (iSTART) begin
                    state_next = ST_RUN;
                    s_next     = '0;
                    b_next     = '0;
                    load_addr  = 1'b1;
                end
            end
            ST_RUN: begin
                if (issue) begin
                    load_addr = 1'b1;
                    if (last_bf) begin
                        b_next = '0;
                        if (last_stage) begin
                            s_next     = '0;
                            state_next = ST_FLUSH;
                        end else begin
                            s_next = s_reg + S_BIT'(1);
                            if (GAP > 0) begin
                                state_next   = ST_GAP;
                                gap_cnt_next = 4'(GAP - 1);
                            end
                        end
                    end else begin
                        b_next = b_reg + A_BIT'(1);
                    end
                end
            end
            ST_GAP: begin
                if (gap_cnt_reg == 4'd0) begin
                    state_next = ST_RUN;
                end else begin
                    gap_cnt_next = gap_cnt_reg - 4'd1;
                end
            end
            ST_FLUSH: begin
                state_next = ST_IDLE;
                done_next  = 1'b1;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Stage s uses only the low s bits of b, scaled up to span the full ROM.
    genvar gi;
    generate
        for (gi = 0; gi < A_BIT; gi++) begin : g_mask
            assign k_next[gi] = b_next[gi] & (int'(s_next) > gi);
        end
    endgenerate

    always_comb begin
        addr_next    = addr_reg;
        st_zero_next = st_zero_reg;
        if (load_addr) begin
            addr_next    = k_next << (A_BIT - int'(s_next));
            st_zero_next = (s_next == '0) && (state_next != ST_FLUSH);
        end
    end

    // Tags trail the issue by one cycle to line up with the ROM read latency.
    always_comb begin
        valid_next     = issue;
        stage_tag_next = issue ? s_reg : '0;
        bf_tag_next    = issue ? b_reg : '0;
        last_tag_next  = issue && last_bf;
    end

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            state_reg     <= ST_IDLE;
            s_reg         <= '0;
            b_reg         <= '0;
            gap_cnt_reg   <= '0;
            addr_reg      <= '0;
            st_zero_reg   <= 1'b0;
            valid_reg     <= 1'b0;
            stage_tag_reg <= '0;
            bf_tag_reg    <= '0;
            last_tag_reg  <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            s_reg         <= s_next;
            b_reg         <= b_next;
            gap_cnt_reg   <= gap_cnt_next;
            addr_reg      <= addr_next;
            st_zero_reg   <= st_zero_next;
            valid_reg     <= valid_next;
            stage_tag_reg <= stage_tag_next;
            bf_tag_reg    <= bf_tag_next;
            last_tag_reg  <= last_tag_next;
            done_reg      <= done_next;
        end
    end

    assign oROM_ADDR = addr_reg;
    assign oST_ZERO  = st_zero_reg;
    assign oVALID    = valid_reg;
    assign oSTAGE    = stage_tag_reg;
    assign oBF_IDX   = bf_tag_reg;
    assign oLAST     = last_tag_reg;
    assign oBUSY     = (state_reg != ST_IDLE);
    assign oDONE     = done_reg;

`ifdef FHT_TWIDDLE_SEQ_STAT_EN
    logic [15:0] stall_cnt_reg;

    always_ff @(posedge iCLK) begin
        if (!iRESET) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_IDLE) && iSTART) begin
            stall_cnt_reg <= '0;
        end else if ((state_reg == ST_RUN) && iSTALL && (stall_cnt_reg != 16'hFFFF)) begin
            stall_cnt_reg <= stall_cnt_reg + 16'd1;
        end
    end

    assign oSTALL_CNT = stall_cnt_reg;
`endif

endmodule

// File: tb/tb_fht_twiddle_seq.sv
// Directed bench for fht_twiddle_seq at A_BIT=2: plain run, stalled run, GAP=2 run,
// mid-run reset and overlapping start pulses, with hand-computed cycle tables.
module tb_fht_twiddle_seq;
    localparam int A_BIT = 2;
    localparam int S_BIT = 2;

    logic iCLK = 1'b0;
    logic iRESET = 1'b0;
    logic iSTART = 1'b0;
    logic iSTALL = 1'b0;

    logic [A_BIT-1:0] d_addr, g_addr, d_bf, g_bf;
    logic [S_BIT-1:0] d_stage, g_stage;
    logic d_st_zero, g_st_zero, d_valid, g_valid, d_last, g_last;
    logic d_busy, g_busy, d_done, g_done;
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
    logic [15:0] d_stall_cnt, g_stall_cnt;
`endif

    fht_twiddle_seq #(.A_BIT(A_BIT), .S_BIT(S_BIT), .GAP(0)) dut (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iSTALL(iSTALL),
        .oROM_ADDR(d_addr), .oST_ZERO(d_st_zero), .oVALID(d_valid),
        .oSTAGE(d_stage), .oBF_IDX(d_bf), .oLAST(d_last),
        .oBUSY(d_busy), .oDONE(d_done)
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
        , .oSTALL_CNT(d_stall_cnt)
`endif
    );

    fht_twiddle_seq #(.A_BIT(A_BIT), .S_BIT(S_BIT), .GAP(2)) dut_gap (
        .iCLK(iCLK), .iRESET(iRESET), .iSTART(iSTART), .iSTALL(iSTALL),
        .oROM_ADDR(g_addr), .oST_ZERO(g_st_zero), .oVALID(g_valid),
        .oSTAGE(g_stage), .oBF_IDX(g_bf), .oLAST(g_last),
        .oBUSY(g_busy), .oDONE(g_done)
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
        , .oSTALL_CNT(g_stall_cnt)
`endif
    );

    always #5 iCLK = ~iCLK;

    int n_checks = 0;
    int n_errors = 0;
    int sel = 0;

    logic [A_BIT-1:0] o_addr, o_bf;
    logic [S_BIT-1:0] o_stage;
    logic o_st_zero, o_valid, o_last, o_busy, o_done;

    assign o_addr    = (sel == 1) ? g_addr    : d_addr;
    assign o_bf      = (sel == 1) ? g_bf      : d_bf;
    assign o_stage   = (sel == 1) ? g_stage   : d_stage;
    assign o_st_zero = (sel == 1) ? g_st_zero : d_st_zero;
    assign o_valid   = (sel == 1) ? g_valid   : d_valid;
    assign o_last    = (sel == 1) ? g_last    : d_last;
    assign o_busy    = (sel == 1) ? g_busy    : d_busy;
    assign o_done    = (sel == 1) ? g_done    : d_done;

    // Scenario 0: plain run, 1: stall cycles 6-8, 2: GAP=2 instance.
    int valid_cyc [0:2][0:11] = '{
        '{2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13},
        '{2, 3, 4, 5, 6, 10, 11, 12, 13, 14, 15, 16},
        '{2, 3, 4, 5, 8, 9, 10, 11, 14, 15, 16, 17}
    };
    // Expected oROM_ADDR per cycle 0..19 while in RUN; -1 means not checked.
    int addr_tab [0:2][0:19] = '{
        '{-1, 0, 0, 0, 0, 0, 2, 0, 2, 0, 1, 2, 3, -1, -1, -1, -1, -1, -1, -1},
        '{-1, 0, 0, 0, 0, 0, 2, 2, 2, 2, 0, 2, 0, 1, 2, 3, -1, -1, -1, -1},
        '{-1, 0, 0, 0, 0, -1, -1, 0, 2, 0, 2, -1, -1, 0, 1, 2, 3, -1, -1, -1}
    };
    int done_cyc [0:2] = '{14, 17, 18};

    task automatic check_val(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge iCLK);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check_val({tag, " addr"}, int'(o_addr), 0);
        check_val({tag, " st_zero"}, int'(o_st_zero), 0);
        check_val({tag, " valid"}, int'(o_valid), 0);
        check_val({tag, " stage"}, int'(o_stage), 0);
        check_val({tag, " bf"}, int'(o_bf), 0);
        check_val({tag, " last"}, int'(o_last), 0);
        check_val({tag, " busy"}, int'(o_busy), 0);
        check_val({tag, " done"}, int'(o_done), 0);
    endtask

    task automatic check_cycle(input int sc, input int c);
        int vi;
        string t;
        vi = -1;
        for (int i = 0; i < 12; i++) begin
            if (valid_cyc[sc][i] == c) vi = i;
        end
        t = $sformatf("sc%0d c%0d", sc, c);
        check_val({t, " valid"}, int'(o_valid), (vi >= 0) ? 1 : 0);
        check_val({t, " stage"}, int'(o_stage), (vi >= 0) ? vi / 4 : 0);
        check_val({t, " bf"}, int'(o_bf), (vi >= 0) ? vi % 4 : 0);
        check_val({t, " last"}, int'(o_last), (vi >= 0 && vi % 4 == 3) ? 1 : 0);
        check_val({t, " busy"}, int'(o_busy), (c >= 1 && c < done_cyc[sc]) ? 1 : 0);
        check_val({t, " done"}, int'(o_done), (c == done_cyc[sc]) ? 1 : 0);
        check_val({t, " st_zero"}, int'(o_st_zero), (c >= 1 && c <= 4) ? 1 : 0);
        if (addr_tab[sc][c] >= 0) begin
            check_val({t, " addr"}, int'(o_addr), addr_tab[sc][c]);
        end
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
        if (sc == 1 && c == 7) check_val({t, " stall_cnt"}, int'(d_stall_cnt), 1);
        if (sc == 2 && c == 1) check_val({t, " stall_cnt clear"}, int'(d_stall_cnt), 0);
`endif
    endtask

    task automatic run_scenario(input int sc);
        int errs_before;
        errs_before = n_errors;
        sel = (sc == 2) ? 1 : 0;
        for (int c = 0; c < 20; c++) begin
            iSTART = (c == 0);
            iSTALL = (sc == 1 && c >= 6 && c <= 8);
            #0;
            check_cycle(sc, c);
            step();
        end
        iSTART = 1'b0;
        iSTALL = 1'b0;
        repeat (8) step();
        $display("scenario %0d: transform complete, %0d new errors", sc, n_errors - errs_before);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        iRESET = 1'b0;
        step();
        step();
        check_all_zero("reset");
        iRESET = 1'b1;
        step();

        run_scenario(0);
        run_scenario(1);
`ifdef FHT_TWIDDLE_SEQ_STAT_EN
        check_val("stall_cnt after done", int'(d_stall_cnt), 3);
`endif
        run_scenario(2);

        // Mid-run reset, then restart at cycle 10.
        sel = 0;
        for (int c = 0; c < 26; c++) begin
            iSTART = (c == 0 || c == 10);
            iRESET = (c != 7);
            #0;
            if (c >= 8 && c <= 10) check_all_zero($sformatf("abort c%0d", c));
            if (c >= 8) check_val($sformatf("abort c%0d done", c), int'(o_done), (c == 24) ? 1 : 0);
            if (c == 11) begin
                check_val("restart addr", int'(o_addr), 0);
                check_val("restart st_zero", int'(o_st_zero), 1);
                check_val("restart busy", int'(o_busy), 1);
                check_val("restart valid", int'(o_valid), 0);
            end
            if (c == 12) begin
                check_val("restart valid1", int'(o_valid), 1);
                check_val("restart stage", int'(o_stage), 0);
                check_val("restart bf", int'(o_bf), 0);
            end
            step();
        end
        iSTART = 1'b0;
        iRESET = 1'b1;
        repeat (8) step();
        $display("abort scenario complete");

        // Start pulses at 0, 5 (ignored) and 14 (coincident with done).
        for (int c = 0; c < 30; c++) begin
            iSTART = (c == 0 || c == 5 || c == 14);
            #0;
            check_val($sformatf("restart c%0d done", c), int'(o_done), (c == 14 || c == 28) ? 1 : 0);
            check_val($sformatf("restart c%0d busy", c), int'(o_busy),
                      ((c >= 1 && c <= 13) || (c >= 15 && c <= 27)) ? 1 : 0);
            if (c == 6) check_val("ignored start addr", int'(o_addr), 2);
            if (c == 15) begin
                check_val("back-to-back addr", int'(o_addr), 0);
                check_val("back-to-back st_zero", int'(o_st_zero), 1);
            end
            if (c == 16) begin
                check_val("back-to-back valid", int'(o_valid), 1);
                check_val("back-to-back stage", int'(o_stage), 0);
                check_val("back-to-back bf", int'(o_bf), 0);
            end
            step();
        end
        iSTART = 1'b0;
        $display("start-pulse scenario complete");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fht_twiddle_seq.md
Name: fht_twiddle_seq

Overview:
Sequencer for the FHT twiddle ROM pair (sin/cos) and its stage-zero selector. On a start pulse it walks every stage and butterfly of an N = 2^(A_BIT+1) point radix-2 FHT. For each butterfly it issues the twiddle ROM address and drives the stage-zero flag. It emits a valid strobe with stage/butterfly tags aligned to the ROM's 1-cycle read latency, and supports datapath backpressure and optional inter-stage bubbles.

Parameters:
A_BIT, 6, ROM address width; butterflies per stage = 2^A_BIT, stages = A_BIT+1
S_BIT, 3, stage index width; must satisfy 2^S_BIT >= A_BIT+1
GAP, 0, idle cycles inserted between stages for datapath drain (0..15)

Ports:
iCLK  in  1  clock
iRESET  in  1  synchronous reset, active-low
iSTART  in  1  start pulse; sampled only in IDLE
iSTALL  in  1  datapath backpressure; holds the current address
oROM_ADDR  out  A_BIT  twiddle ROM address
oST_ZERO  out  1  high while the issued address belongs to stage 0
oVALID  out  1  ROM output valid this cycle; tags below apply
oSTAGE  out  S_BIT  stage tag aligned with oVALID
oBF_IDX  out  A_BIT  butterfly tag aligned with oVALID
oLAST  out  1  with oVALID: last butterfly of the current stage
oBUSY  out  1  high in RUN/GAP/FLUSH
oDONE  out  1  one-cycle pulse after the final twiddle is delivered

Behaviour:
- Reset (iRESET=0 at a clock edge): state IDLE, all counters 0, every output 0. This applies mid-operation: the transform is aborted and no oDONE is produced.
- States:
  - IDLE -> RUN on iSTART.
  - RUN: the current address is issued each cycle.
  - GAP: counts GAP cycles.
  - FLUSH: one cycle.
  - DONE: not a state; oDONE is a registered pulse on the FLUSH->IDLE edge.
- Issue condition: issue = (state==RUN) & !iSTALL.
- RUN with issue=1:
  - Advance b; on b = 2^A_BIT-1, wrap b to 0 and increment s.
  - If s was the last stage (A_BIT), go to FLUSH.
  - Otherwise go to GAP if GAP>0, else stay in RUN.
- RUN with iSTALL=1: s, b and oROM_ADDR are held; the ROM re-reads the same address, so its data stays consistent.
- GAP: oROM_ADDR held, no issue; after GAP cycles return to RUN.
- FLUSH: no issue; carries the final oVALID; then IDLE with oDONE=1 for 1 cycle.
- Address arithmetic: k = b & (2^s - 1); oROM_ADDR = k << (A_BIT - s). Compute in A_BIT bits; for s=0 the address is always 0.
- oROM_ADDR and oST_ZERO are registered and change on the edge that enters or advances RUN, so the ROM samples them the following edge.
- oST_ZERO = (s==0) for the issued address.
- Latency: oVALID(t+1) = issue(t). oSTAGE, oBF_IDX and oLAST are delayed copies of the issued s, b and (b==2^A_BIT-1), and are zero when oVALID=0.
- iSTART while oBUSY=1: ignored. iSTART in the same cycle as oDONE: accepted (state is IDLE).
- iSTALL in GAP/FLUSH/IDLE: no effect.
- Total cycles without stalls: (A_BIT+1)*2^A_BIT issue cycles + A_BIT*GAP + 1 flush.

Optional Feature:
Macro FHT_TWIDDLE_SEQ_STAT_EN.
- Defined: adds output oSTALL_CNT [15:0].
  - Cleared on reset and on accepted iSTART.
  - Increments (saturating at 16'hFFFF) each cycle with state==RUN & iSTALL.
  - Holds after oDONE until the next start.
- Undefined: port and counter are absent; behaviour otherwise identical.

Test Plan:
- A_BIT=2, GAP=0, iSTART at cycle 0, no stalls -> oROM_ADDR sequence cycles 1-12:
  - stage 0: 0,0,0,0; stage 1: 0,2,0,2; stage 2: 0,1,2,3.
  - oVALID cycles 2-13; oST_ZERO high cycles 1-4; oLAST at cycles 5, 9, 13; oDONE cycle 14 only; oBUSY cycles 1-13.
- Same setup, iSTALL=1 cycles 6-8 -> oROM_ADDR stays 2 during cycles 6-8; oVALID low cycles 7-9; tag sequence unchanged; oDONE at cycle 17.
- A_BIT=2, GAP=2 -> two cycles with no oVALID after each of the first two stages; oDONE at cycle 18; address sequence as in the first scenario.
- iRESET=0 at cycle 7 mid-run -> cycle 8: all outputs 0, oBUSY=0; no oDONE; a new iSTART at cycle 10 restarts at stage 0, b 0.
- iSTART pulses at cycles 0, 5 and 14 -> the cycle-5 pulse is ignored; the cycle-14 pulse (coincident with oDONE) starts a second transform with oROM_ADDR=0 and oST_ZERO=1 at cycle 15.
- With FHT_TWIDDLE_SEQ_STAT_EN, stall scenario -> oSTALL_CNT=3 after oDONE; cleared to 0 on the next accepted iSTART.
